bomb_game_ctrl: RTL
===================

Name: bomb_game_ctrl

Overview:
- Parametrised game sequencer for the bomb-dismantling game.
- Generates a random code per round and drives the enables for the bomb display, code display, countdown and code-entry modules.
- Counts down the defuse time and limits the number of wrong entries.
- Resolves each round to WIN or LOSE, then supports manual or automatic restart.
- Sits between the switch/button inputs and the display, timer and verify modules.

Parameters:
- CODE_W, 5: width of the generated code.
- TIME_S, 20: countdown length in seconds.
- SHOW_S, 3: seconds the code is displayed before arming.
- MAX_TRIES, 3: wrong entries allowed per round (>=1).
- TICKS_PER_S, 50000000: clk cycles per second tick.

Ports:
- clk  in  1  system clock.
- Rst  in  1  synchronous active-low reset.
- enable  in  1  master switch; low forces IDLE.
- start_btn  in  1  level; rising edge detected internally.
- auto_restart  in  1  1-cycle pulse; restarts from WIN/LOSE.
- fail_in  in  1  1-cycle pulse from verify: wrong code entered.
- success_in  in  1  1-cycle pulse from verify: correct code.
- code  out  CODE_W  current round code.
- bomb_on  out  1  bomb display enable.
- show_on  out  1  code display enable.
- timer_on  out  1  countdown display enable.
- input_on  out  1  code-entry/verify enable.
- secs_left  out  $clog2(TIME_S+1)  remaining seconds.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining wrong entries allowed.
- win  out  1  level, high in WIN.
- lose  out  1  level, high in LOSE.
- round_done  out  1  1-cycle pulse on entry to WIN or LOSE.

Behaviour:
- Reset (Rst=0 at a clk edge):
  - state=IDLE.
  - All outputs 0, including code=0, secs_left=0 and tries_left=0.
  - Prescaler and free counter cleared.
  - Start-edge register set to 1, so a button held through reset does not start a round.
- Free counter: CODE_W-bit, increments every cycle while enable=1, wraps at 2^CODE_W.
- Code latch on every round start: code <= free_counter XOR code (previous). This reproduces deterministically in simulation.
- Prescaler:
  - Counts 0..TICKS_PER_S-1 and emits tick when it wraps.
  - Cleared on every state entry, so the first tick comes TICKS_PER_S cycles after entry.
- States and outputs:
  - IDLE: all enables 0. A start_btn rising edge goes to SHOW.
  - SHOW:
    - On entry: latch code, secs_left=TIME_S, tries_left=MAX_TRIES.
    - Outputs: bomb_on=1, show_on=1, timer_on=0, input_on=0.
    - After SHOW_S ticks go to ARMED.
  - ARMED:
    - Outputs: bomb_on=1, show_on=0, timer_on=1, input_on=1.
    - Each tick decrements secs_left.
    - Tick while secs_left==1 goes to LOSE, with secs_left=0.
    - success_in goes to WIN; secs_left is frozen.
    - fail_in with tries_left>1 decrements tries_left.
    - fail_in with tries_left==1 sets tries_left=0 and goes to LOSE.
  - WIN / LOSE:
    - Outputs: bomb_on=0, timer_on=0, input_on=0, show_on=0.
    - win or lose is 1, matching the state.
    - code, secs_left and tries_left hold their values.
    - A start_btn edge or an auto_restart pulse goes to SHOW (new round).
- Priority within a cycle in ARMED: success_in > fail_in > timeout tick.
- fail_in and success_in are ignored outside ARMED.
- round_done is high exactly one cycle: the first cycle in WIN or LOSE.
- enable=0:
  - Next state is IDLE; all enables, win, lose and round_done are 0.
  - code, secs_left and tries_left clear to 0.
  - Free counter and prescaler hold.
  - Overrides all other inputs.
  - A start_btn edge in the same cycle is ignored.
- Re-enable returns to IDLE and waits for a start_btn edge. No auto-start.
- A start_btn edge in SHOW or ARMED is ignored. A held button does not retrigger.
- Output latency: outputs are registered and reflect the state one cycle after the causing input edge.

Test Plan:
All scenarios use CODE_W=5, TIME_S=3, SHOW_S=1, MAX_TRIES=2, TICKS_PER_S=4.
1. Reset with start_btn held high, then Rst=1 and enable=1 -> state stays IDLE, all outputs 0; release then press start_btn -> show_on=1, bomb_on=1, secs_left=3, tries_left=2, code=free_counter value.
2. Start, no inputs -> ARMED 4 cycles after SHOW entry; secs_left 3->2->1->0 at 4-cycle spacing; lose=1 and round_done pulses once; timer_on=input_on=bomb_on=0.
3. In ARMED: fail_in then fail_in -> tries_left 2->1->0, second pulse goes to LOSE. Repeat with success_in and fail_in in the same cycle -> WIN, tries_left unchanged.
4. success_in in the same cycle as the final tick (secs_left==1) -> WIN with secs_left=1, win=1, round_done one cycle.
5. From WIN, auto_restart pulse -> SHOW; new code = old code XOR counter; secs_left=3, tries_left=2.
6. Drop enable mid-ARMED -> next cycle IDLE, all enables 0, code=0; raise enable -> stays IDLE until start_btn edge.

Source files
------------

// File: rtl/bomb_game_ctrl.sv
// rtl/bomb_game_ctrl.sv - round sequencer for the bomb-dismantling game
module bomb_game_ctrl #(
  parameter int CODE_W      = 5,
  parameter int TIME_S      = 20,
  parameter int SHOW_S      = 3,
  parameter int MAX_TRIES   = 3,
  parameter int TICKS_PER_S = 50000000
) (
  input  logic                           clk,
  input  logic                           Rst,
  input  logic                           enable,
  input  logic                           start_btn,
  input  logic                           auto_restart,
  input  logic                           fail_in,
  input  logic                           success_in,
  output logic [CODE_W-1:0]              code,
  output logic                           bomb_on,
  output logic                           show_on,
  output logic                           timer_on,
  output logic                           input_on,
  output logic [$clog2(TIME_S+1)-1:0]    secs_left,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic                           win,
  output logic                           lose,
  output logic                           round_done
);

  localparam int SW = $clog2(TIME_S + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int PW = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
  localparam int HW = (SHOW_S > 1) ? $clog2(SHOW_S) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_ARMED,
    S_WIN,
    S_LOSE
  } state_t;

  state_t          state, state_nx;
  logic            start_prev;
  logic            start_edge;
  logic [CODE_W-1:0] free_cnt;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [HW-1:0]   show_cnt, show_nx;
  logic [CODE_W-1:0] code_nx;
  logic [SW-1:0]   secs_nx;
  logic [TW-1:0]   tries_nx;
  logic            round_start;
  logic            fail_lose;

  assign start_edge = start_btn & ~start_prev;
  assign tick       = (presc == PW'(TICKS_PER_S - 1));

  // Next-state and next round-data computation; enable low overrides everything.
  always_comb begin
    state_nx    = state;
    code_nx     = code;
    secs_nx     = secs_left;
    tries_nx    = tries_left;
    show_nx     = show_cnt;
    round_start = 1'b0;
    fail_lose   = 1'b0;
    if (!enable) begin
      state_nx = S_IDLE;
      code_nx  = '0;
      secs_nx  = '0;
      tries_nx = '0;
      show_nx  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) round_start = 1'b1;
        end
        S_SHOW: begin
          if (tick) begin
            if (show_cnt == HW'(SHOW_S - 1)) state_nx = S_ARMED;
            else                             show_nx  = show_cnt + HW'(1);
          end
        end
        S_ARMED: begin
          if (success_in) begin
            state_nx = S_WIN;
          end else begin
            if (fail_in) begin
              if (tries_left == TW'(1)) begin
                tries_nx  = '0;
                state_nx  = S_LOSE;
                fail_lose = 1'b1;
              end else begin
                tries_nx = tries_left - TW'(1);
              end
            end
            // A non-fatal wrong entry does not swallow the second tick.
            if (tick && !fail_lose) begin
              if (secs_left == SW'(1)) begin
                secs_nx  = '0;
                state_nx = S_LOSE;
              end else begin
                secs_nx = secs_left - SW'(1);
              end
            end
          end
        end
        S_WIN, S_LOSE: begin
          if (start_edge || auto_restart) round_start = 1'b1;
        end
        default: state_nx = S_IDLE;
      endcase
      if (round_start) begin
        state_nx = S_SHOW;
        code_nx  = free_cnt ^ code;
        secs_nx  = SW'(TIME_S);
        tries_nx = TW'(MAX_TRIES);
        show_nx  = '0;
      end
    end
  end

  // State, round data and registered output decode of the next state.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state      <= S_IDLE;
      code       <= '0;
      secs_left  <= '0;
      tries_left <= '0;
      show_cnt   <= '0;
      bomb_on    <= 1'b0;
      show_on    <= 1'b0;
      timer_on   <= 1'b0;
      input_on   <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state      <= state_nx;
      code       <= code_nx;
      secs_left  <= secs_nx;
      tries_left <= tries_nx;
      show_cnt   <= show_nx;
      bomb_on    <= (state_nx == S_SHOW) || (state_nx == S_ARMED);
      show_on    <= (state_nx == S_SHOW);
      timer_on   <= (state_nx == S_ARMED);
      input_on   <= (state_nx == S_ARMED);
      win        <= (state_nx == S_WIN);
      lose       <= (state_nx == S_LOSE);
      round_done <= ((state_nx == S_WIN) || (state_nx == S_LOSE)) && (state_nx != state);
    end
  end

  // Start button history; reset to 1 so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (!Rst) start_prev <= 1'b1;
    else      start_prev <= start_btn;
  end

  // Free-running code source, frozen while disabled.
  always_ff @(posedge clk) begin
    if (!Rst)        free_cnt <= '0;
    else if (enable) free_cnt <= free_cnt + CODE_W'(1);
  end

  // Seconds prescaler, restarted on every state change so ticks align to entry.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      presc <= '0;
    end else if (enable) begin
      if (state_nx != state || tick) presc <= '0;
      else                           presc <= presc + PW'(1);
    end
  end

endmodule
